// File: rtl/decode_scoreboard_pkg.sv
// Shared constants and decode-facing structs for the register scoreboard.
// Struct widths follow the SB_* constants; top/bank parameters default to them.
package decode_scoreboard_pkg;

  localparam logic SB_BANK_INT = 1'b0;
  localparam logic SB_BANK_FP  = 1'b1;

  localparam int SB_NUM_REGS = 32;
  localparam int SB_ADDR_W   = 5;
  localparam int SB_NUM_RD   = 3;
  localparam int SB_LAT_W    = 4;
  localparam int SB_MAX_VAR  = 4;
  localparam int SB_VCNT_W   = $clog2(SB_MAX_VAR + 1);

  typedef struct packed {
    logic                                valid;
    logic [SB_NUM_RD-1:0]                rden;
    logic [SB_NUM_RD-1:0]                rbank;
    logic [SB_NUM_RD-1:0][SB_ADDR_W-1:0] raddr;
    logic                                wren;
    logic                                wbank;
    logic [SB_ADDR_W-1:0]                waddr;
    logic [SB_LAT_W-1:0]                 lat;
    logic                                flush;
  } scoreboard_in_type;

  typedef struct packed {
    logic                 ready;
    logic                 stall_raw;
    logic                 stall_waw;
    logic                 stall_struct;
    logic [SB_VCNT_W-1:0] var_count;
    logic                 err;
  } scoreboard_out_type;

endpackage

// File: rtl/decode_scoreboard_bank.sv
// One register file's busy tracking: fixed-latency countdowns, variable-latency
// pending flags and hazard lookups. SCOREBOARD_WB_BYPASS_EN lets wb clear a hazard same-cycle.
module scoreboard_bank
  import decode_scoreboard_pkg::*;
#(
  parameter int   NUM_REGS = SB_NUM_REGS,
  parameter int   ADDR_W   = SB_ADDR_W,
  parameter int   NUM_RD   = SB_NUM_RD,
  parameter int   LAT_W    = SB_LAT_W,
  parameter logic BANK     = SB_BANK_INT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          set_fix,
  input  logic                          set_var,
  input  logic [ADDR_W-1:0]             waddr,
  input  logic [LAT_W-1:0]              lat,
  input  logic                          wr_chk,
  input  logic [NUM_RD-1:0]             rd_chk,
  input  logic [NUM_RD-1:0][ADDR_W-1:0] raddr,
  input  logic                          wb_hit,
  input  logic [ADDR_W-1:0]             wb_addr,
  input  logic                          kill,
  output logic                          rd_busy,
  output logic                          wr_busy,
  output logic                          wb_pend
);

  logic [NUM_REGS-1:0][LAT_W-1:0] cnt_q, cnt_d;
  logic [NUM_REGS-1:0]            pend_q, pend_d;
  logic [NUM_REGS-1:0]            busy, wb_clr, trk;

  // Hazard view; kept apart from next-state so issue->fire->update has no comb loop.
  always_comb begin
    trk    = '1;
    busy   = '0;
    wb_clr = '0;
    if (BANK == SB_BANK_INT) trk[0] = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      wb_clr[r] = wb_hit & (wb_addr == ADDR_W'(r)) & pend_q[r];
`ifdef SCOREBOARD_WB_BYPASS_EN
      busy[r] = trk[r] & ((cnt_q[r] != '0) | (pend_q[r] & ~wb_clr[r]));
`else
      busy[r] = trk[r] & ((cnt_q[r] != '0) | pend_q[r]);
`endif
    end
  end

  // Counter holds L-1 so a reader issued L cycles after the writer sees it free.
  always_comb begin
    cnt_d  = cnt_q;
    pend_d = pend_q;
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - LAT_W'(1) : '0;
      if (set_fix & trk[r] & (waddr == ADDR_W'(r)))
        cnt_d[r] = lat - LAT_W'(1);
      pend_d[r] = ~kill & trk[r] &
                  ((pend_q[r] & ~wb_clr[r]) | (set_var & (waddr == ADDR_W'(r))));
    end
  end

  always_comb begin
    rd_busy = 1'b0;
    for (int i = 0; i < NUM_RD; i++)
      rd_busy = rd_busy | (rd_chk[i] & busy[raddr[i]]);
    wr_busy = wr_chk & busy[waddr];
    wb_pend = pend_q[wb_addr];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      pend_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

endmodule

// File: rtl/decode_scoreboard.sv
// Decode-stage hazard scoreboard over int and fp register banks.
// Define SCOREBOARD_WB_BYPASS_EN to let writeback release a register in the same cycle.
module decode_scoreboard
  import decode_scoreboard_pkg::*;
#(
  parameter int NUM_REGS = SB_NUM_REGS,
  parameter int ADDR_W   = SB_ADDR_W,
  parameter int NUM_RD   = SB_NUM_RD,
  parameter int LAT_W    = SB_LAT_W,
  parameter int MAX_VAR  = SB_MAX_VAR,
  parameter int VCNT_W   = $clog2(MAX_VAR + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_valid,
  input  logic [NUM_RD-1:0]        issue_rden,
  input  logic [NUM_RD-1:0]        issue_rbank,
  input  logic [NUM_RD*ADDR_W-1:0] issue_raddr,
  input  logic                     issue_wren,
  input  logic                     issue_wbank,
  input  logic [ADDR_W-1:0]        issue_waddr,
  input  logic [LAT_W-1:0]         issue_lat,
  input  logic                     flush,
  input  logic                     kill_var,
  input  logic                     wb_valid,
  input  logic                     wb_bank,
  input  logic [ADDR_W-1:0]        wb_waddr,
  output logic                     issue_ready,
  output logic                     stall_raw,
  output logic                     stall_waw,
  output logic                     stall_struct,
  output logic [VCNT_W-1:0]        var_count,
  output logic                     err
);

  scoreboard_in_type  sb_in;
  scoreboard_out_type sb_out;

  logic              lat_nz, fire, wr_fire, var_inc, wb_ok;
  logic [1:0]        rd_busy, wr_busy, wb_pend;
  logic [VCNT_W-1:0] var_count_q, var_count_d;
  logic              err_q, err_d;

  always_comb begin
    sb_in.valid = issue_valid;
    sb_in.rden  = issue_rden;
    sb_in.rbank = issue_rbank;
    sb_in.raddr = issue_raddr;
    sb_in.wren  = issue_wren;
    sb_in.wbank = issue_wbank;
    sb_in.waddr = issue_waddr;
    sb_in.lat   = issue_lat;
    sb_in.flush = flush;
  end

  assign lat_nz = |sb_in.lat;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic              wsel;
    logic [NUM_RD-1:0] rd_chk;

    always_comb begin
      wsel   = (sb_in.wbank == 1'(b));
      rd_chk = '0;
      for (int i = 0; i < NUM_RD; i++)
        rd_chk[i] = sb_in.valid & sb_in.rden[i] & (sb_in.rbank[i] == 1'(b));
    end

    scoreboard_bank #(
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W),
      .NUM_RD   (NUM_RD),
      .LAT_W    (LAT_W),
      .BANK     (1'(b))
    ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .set_fix (wr_fire & wsel & lat_nz),
      .set_var (wr_fire & wsel & ~lat_nz),
      .waddr   (sb_in.waddr),
      .lat     (sb_in.lat),
      .wr_chk  (sb_in.valid & sb_in.wren & wsel),
      .rd_chk  (rd_chk),
      .raddr   (sb_in.raddr),
      .wb_hit  (wb_valid & (wb_bank == 1'(b))),
      .wb_addr (wb_waddr),
      .kill    (kill_var),
      .rd_busy (rd_busy[b]),
      .wr_busy (wr_busy[b]),
      .wb_pend (wb_pend[b])
    );
  end

  // Structural limit is checked against the registered count only; wb frees a slot next cycle.
  always_comb begin
    sb_out.stall_raw    = |rd_busy;
    sb_out.stall_waw    = |wr_busy;
    sb_out.stall_struct = sb_in.valid & sb_in.wren & ~lat_nz &
                          (var_count_q == VCNT_W'(MAX_VAR));
    sb_out.ready        = ~(sb_out.stall_raw | sb_out.stall_waw | sb_out.stall_struct);
    sb_out.var_count    = var_count_q;
    sb_out.err          = err_q;
  end

  assign issue_ready  = sb_out.ready;
  assign stall_raw    = sb_out.stall_raw;
  assign stall_waw    = sb_out.stall_waw;
  assign stall_struct = sb_out.stall_struct;
  assign var_count    = sb_out.var_count;
  assign err          = sb_out.err;

  // Var writes to int x0 are never tracked, so they must not occupy a slot either.
  always_comb begin
    fire        = sb_in.valid & issue_ready & ~sb_in.flush;
    wr_fire     = fire & sb_in.wren;
    var_inc     = wr_fire & ~lat_nz &
                  ~((sb_in.wbank == SB_BANK_INT) & (sb_in.waddr == '0));
    wb_ok       = wb_valid & wb_pend[wb_bank];
    var_count_d = kill_var ? '0
                : var_count_q + VCNT_W'(var_inc) - VCNT_W'(wb_ok);
    err_d       = err_q | (wb_valid & ~wb_pend[wb_bank]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      var_count_q <= '0;
      err_q       <= 1'b0;
    end else begin
      var_count_q <= var_count_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_decode_scoreboard.sv
// Directed plus random checks of decode_scoreboard against a cycle-stamp / pending-set model.
module tb_decode_scoreboard;
  localparam int NR = 32, AW = 5, RD = 3, LW = 4, MV = 4, VW = 3;

  logic          clk = 1'b0, rst = 1'b0;
  logic          issue_valid, issue_wren, issue_wbank, flush, kill_var, wb_valid, wb_bank;
  logic [RD-1:0] issue_rden, issue_rbank;
  logic [RD*AW-1:0] issue_raddr;
  logic [AW-1:0] issue_waddr, wb_waddr;
  logic [LW-1:0] issue_lat;
  logic          issue_ready, stall_raw, stall_waw, stall_struct, err;
  logic [VW-1:0] var_count;

  decode_scoreboard dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_rden(issue_rden),
    .issue_rbank(issue_rbank), .issue_raddr(issue_raddr), .issue_wren(issue_wren),
    .issue_wbank(issue_wbank), .issue_waddr(issue_waddr), .issue_lat(issue_lat),
    .flush(flush), .kill_var(kill_var), .wb_valid(wb_valid), .wb_bank(wb_bank),
    .wb_waddr(wb_waddr), .issue_ready(issue_ready), .stall_raw(stall_raw),
    .stall_waw(stall_waw), .stall_struct(stall_struct), .var_count(var_count), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  // Model: a register is busy while the cycle number is below its free time, or while pending.
  bit m_pend [2][NR];
  int m_free [2][NR];
  int m_cyc = 0;
  bit m_err = 0;

  function automatic bit m_busy(int b, int a);
    bit p;
    if (b == 0 && a == 0) return 1'b0;
    p = m_pend[b][a];
`ifdef SCOREBOARD_WB_BYPASS_EN
    if (wb_valid && int'(wb_bank) == b && int'(wb_waddr) == a) p = 1'b0;
`endif
    return (m_cyc < m_free[b][a]) || p;
  endfunction

  function automatic int m_vc();
    int n = 0;
    foreach (m_pend[b, a]) n += int'(m_pend[b][a]);
    return n;
  endfunction

  function automatic logic [7:0] m_expect();
    bit raw = 0, waw, st;
    for (int i = 0; i < RD; i++)
      if (issue_valid && issue_rden[i] && m_busy(int'(issue_rbank[i]), int'(issue_raddr[i*AW +: AW])))
        raw = 1;
    waw = issue_valid && issue_wren && m_busy(int'(issue_wbank), int'(issue_waddr));
    st  = issue_valid && issue_wren && issue_lat == 0 && m_vc() == MV;
    return {!(raw || waw || st), raw, waw, st, VW'(m_vc()), m_err};
  endfunction

  task automatic m_reset();
    foreach (m_pend[b, a]) begin m_pend[b][a] = 0; m_free[b][a] = 0; end
    m_err = 0;
  endtask

  task automatic m_clock();
    logic [7:0] e;
    bit fire;
    e = m_expect();
    fire = issue_valid && e[7] && !flush;
    if (wb_valid) begin
      if (m_pend[wb_bank][wb_waddr]) m_pend[wb_bank][wb_waddr] = 0;
      else m_err = 1;
    end
    if (kill_var) foreach (m_pend[b, a]) m_pend[b][a] = 0;
    if (fire && issue_wren && !(issue_wbank == 0 && issue_waddr == 0)) begin
      if (issue_lat != 0) m_free[issue_wbank][issue_waddr] = m_cyc + int'(issue_lat);
      else if (!kill_var) m_pend[issue_wbank][issue_waddr] = 1;
    end
    m_cyc++;
  endtask

  task automatic look(string tag);
    logic [7:0] obs, exp;
    @(negedge clk);
    exp = m_expect();
    obs = {issue_ready, stall_raw, stall_waw, stall_struct, var_count, err};
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s obs=%b exp=%b", tag, obs, exp);
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_clock();
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; issue_rden = '0; issue_rbank = '0; issue_raddr = '0;
    issue_wren = 0; issue_wbank = 0; issue_waddr = '0; issue_lat = '0;
    flush = 0; kill_var = 0; wb_valid = 0; wb_bank = 0; wb_waddr = '0;
  endtask

  task automatic rd(int slot, int b, int a);
    issue_valid = 1; issue_rden[slot] = 1'b1; issue_rbank[slot] = 1'(b);
    issue_raddr[slot*AW +: AW] = AW'(a);
  endtask

  task automatic wr(int b, int a, int lat);
    issue_valid = 1; issue_wren = 1; issue_wbank = 1'(b);
    issue_waddr = AW'(a); issue_lat = LW'(lat);
  endtask

  task automatic wb(int b, int a);
    wb_valid = 1; wb_bank = 1'(b); wb_waddr = AW'(a);
  endtask

  task automatic rand_inputs();
    int q[$];
    idle();
    issue_valid = ($urandom % 4) != 0;
    for (int i = 0; i < RD; i++) begin
      issue_rden[i]  = 1'($urandom % 2);
      issue_rbank[i] = 1'($urandom % 2);
      issue_raddr[i*AW +: AW] = AW'($urandom % 8);
    end
    issue_wren  = 1'($urandom % 2);
    issue_wbank = 1'($urandom % 2);
    issue_waddr = AW'($urandom % 8);
    issue_lat   = (($urandom % 3) == 0) ? '0 : LW'($urandom % 16);
    flush       = ($urandom % 8) == 0;
    kill_var    = ($urandom % 40) == 0;
    foreach (m_pend[b, a]) if (m_pend[b][a]) q.push_back(b * NR + a);
    if (q.size() > 0 && ($urandom % 2) == 1) begin
      int k = q[$urandom % q.size()];
      wb(k / NR, k % NR);
    end else if (($urandom % 60) == 0) begin
      wb(int'($urandom % 2), int'($urandom % 8));
    end
  endtask

  initial begin
    idle();
    m_reset();
    rst = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1;

    look("reset_idle");
    chk("reset_ready", issue_ready, 1); chk("reset_vc", var_count, 0); chk("reset_err", err, 0);
    tick();

    // x0 is never tracked
    idle(); wr(0, 0, 5); rd(0, 0, 0); look("x0_wr"); chk("x0_wr_ready", issue_ready, 1); tick();
    idle(); rd(0, 0, 0); look("x0_rd"); chk("x0_rd_raw", stall_raw, 0); tick();

    // fixed latency 3
    idle(); wr(0, 5, 3); look("x5_issue"); tick();
    for (int k = 1; k <= 3; k++) begin
      idle(); rd(1, 0, 5); look("x5_read");
      if (k < 3) chk("x5_raw", stall_raw, 1);
      else       chk("x5_ready", issue_ready, 1);
      tick();
    end

    // fp variable latency
    idle(); wr(1, 2, 0); look("f2_issue"); tick();
    idle(); rd(0, 1, 2); look("f2_wait"); chk("f2_stall", stall_raw, 1); tick();
    idle(); rd(0, 1, 2); wb(1, 2); look("f2_wb");
`ifdef SCOREBOARD_WB_BYPASS_EN
    chk("f2_wb_ready", issue_ready, 1);
`else
    chk("f2_wb_ready", issue_ready, 0);
`endif
    tick();
    idle(); rd(0, 1, 2); look("f2_after"); chk("f2_after_ready", issue_ready, 1); tick();

    // structural limit
    for (int a = 1; a <= 4; a++) begin idle(); wr(0, a, 0); look("var_fill"); tick(); end
    idle(); wr(0, 6, 0); look("var_full"); chk("struct", stall_struct, 1); chk("vc4", var_count, 4); tick();
    idle(); wr(0, 6, 0); wb(0, 1); look("var_wb"); chk("struct_wb", stall_struct, 1); tick();
    idle(); wr(0, 6, 0); look("var_free"); chk("struct_free", issue_ready, 1); chk("vc3", var_count, 3); tick();

    // WAW and flush
    idle(); wb(0, 2); look("wb_x2"); tick();
    idle(); wr(0, 7, 0); look("x7_var"); chk("x7_ready", issue_ready, 1); tick();
    idle(); wr(0, 7, 2); look("x7_waw"); chk("waw", stall_waw, 1); tick();
    idle(); wr(0, 9, 2); flush = 1; look("flush"); chk("flush_ready", issue_ready, 1); tick();
    idle(); rd(2, 0, 9); look("post_flush"); chk("flush_nochg", stall_raw, 0); tick();

    // kill_var and sticky err
    idle(); wb(0, 3); look("wb_x3"); tick();
    idle(); kill_var = 1; look("kill"); chk("kill_vc3", var_count, 3); tick();
    idle(); look("post_kill"); chk("kill_vc0", var_count, 0); tick();
    idle(); wb(0, 1); look("bad_wb"); chk("err_pre", err, 0); tick();
    idle(); look("err_set"); chk("err_set", err, 1); tick();
    idle(); look("err_hold"); chk("err_sticky", err, 1); tick();
    idle(); kill_var = 1; wr(0, 12, 0); look("kill_vs_fire"); tick();
    idle(); rd(0, 0, 12); look("kill_won"); chk("kill_won_raw", stall_raw, 0); chk("kill_won_vc", var_count, 0); tick();

    // async reset mid-cycle
    idle(); wr(0, 10, 0); look("pre_rst_var"); tick();
    idle(); wr(0, 11, 9); look("pre_rst_fix"); tick();
    idle(); rd(0, 0, 11); rd(1, 0, 10); look("pre_rst");
    rst = 0; #1;
    m_reset();
    chk("rst_ready", issue_ready, 1); chk("rst_vc", var_count, 0); chk("rst_err", err, 0);
    #1 rst = 1;
    tick();
    idle(); rd(0, 0, 11); look("post_rst"); chk("post_rst_raw", stall_raw, 0); tick();

    repeat (500) begin
      rand_inputs();
      look("rand");
      tick();
    end

    idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
